class_select_ctrl: RTL
======================

CLASS_SELECT_CTRL -- requirements
Module: class_select_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CLASSES, 10, scores per frame; legal range 2..255.
- DATA_W, 8, unsigned score width.
- IDX_W, 8, class index width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- abort, input, 1, synchronous frame discard.
- in_valid, input, 1, score beat valid.
- in_ready, output, 1, block accepts a score beat.
- in_data, input, DATA_W, unsigned class score.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- out_index, output, IDX_W, winning class index.
- out_score, output, DATA_W, winning score.
- busy, output, 1, frame in progress (state != IDLE).
REQ-003 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n; no other clock or reset SHALL exist.

Function
REQ-004 A beat SHALL transfer on a rising edge where in_valid=1 and in_ready=1.
REQ-005 A result SHALL transfer on a rising edge where out_valid=1 and out_ready=1.
REQ-006 Scores SHALL arrive in class order: beat k of a frame carries class k, k = 0..NUM_CLASSES-1.
REQ-007 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-008 IDLE: in_ready=1, out_valid=0. A beat SHALL load max_score=in_data, max_idx=0, cnt=1, and move to ACCUM.
REQ-009 ACCUM: in_ready=1, out_valid=0. Each beat SHALL:
- replace max_score/max_idx with in_data/cnt only if in_data > max_score (strict compare);
- increment cnt.
REQ-010 The beat accepted with cnt = NUM_CLASSES-1 SHALL be compared as in REQ-009 and move the FSM to DONE.
REQ-011 Ties SHALL resolve to the lowest class index.
REQ-012 DONE: in_ready=0, out_valid=1. out_index and out_score SHALL hold stable until the result transfers; on transfer the FSM SHALL go to IDLE.
REQ-013 Latency: out_valid SHALL assert on the cycle after the final beat transfers.
REQ-014 Throughput: the first beat of the next frame SHALL be acceptable on the cycle after the result transfers (one bubble cycle per frame).
REQ-015 abort=1 in any state SHALL, at the next edge:
- return the FSM to IDLE;
- clear cnt, max_score and max_idx;
- take priority over a simultaneous input or output transfer;
- produce no result for the aborted frame.
REQ-016 In IDLE and ACCUM, out_index and out_score SHALL show the running max_idx and max_score; these values are meaningful only while out_valid=1.
REQ-017 cnt SHALL be IDX_W bits wide and SHALL never exceed NUM_CLASSES-1.
REQ-018 All comparisons SHALL be unsigned.

Reset
REQ-019 While rst_n=0, the block SHALL force: state=IDLE, cnt=0, max_score=0, max_idx=0, out_valid=0, busy=0.
REQ-020 in_ready SHALL be 1 after reset is released.
REQ-021 Reset asserted mid-frame or in DONE SHALL discard the partial frame or pending result.
REQ-022 Reset deassertion SHALL be synchronised externally; the block assumes a clean release.

Structure
REQ-023 A shared package SHALL hold:
- the state enumeration (IDLE, ACCUM, DONE);
- NUM_CLASSES, DATA_W and IDX_W default constants.
REQ-024 The compare-and-update step SHALL be one sub-module, class_max_update. It SHALL be purely combinational, with inputs (cur_score, cur_idx, new_score, new_idx) and outputs (sel_score, sel_idx).

Verification
REQ-025 Frame 3,9,1,7,9,0,2,8,4,5 with out_ready=1 -> out_index=1, out_score=9 (tie with index 4 rejected); out_valid asserts exactly one cycle after the 10th beat.
REQ-026 Frame of all 0 -> out_index=0, out_score=0.
REQ-027 Frame 0,0,0,0,0,0,0,0,0,255 with out_ready held 0 for 5 cycles -> out_valid, out_index=9 and out_score=255 stay stable; in_ready=0 throughout; the FSM returns to IDLE after the handshake.
REQ-028 abort pulsed after beat 4, then a full new frame 1..10 -> exactly one result, out_index=9, out_score=10.
REQ-029 Random in_valid gaps (50%) on back-to-back frames -> every result matches a reference argmax model with lowest-index tie-break; one bubble cycle per frame.
REQ-030 rst_n asserted in ACCUM and in DONE -> all outputs take their REQ-019 values immediately; the next frame completes correctly.

Source files
------------

// File: rtl/class_select_ctrl_pkg.sv
// Shared types and default sizing for the class-select (argmax) controller.
// Imported by the top level and the compare-and-update helper.
package class_select_ctrl_pkg;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int DATA_W_DEF      = 8;
    localparam int IDX_W_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/class_select_ctrl_max_update.sv
// Combinational compare-and-update step of the running argmax.
// A strict compare keeps the earlier (lower) index on ties.
module class_max_update #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8
) (
    input  logic [DATA_W-1:0] cur_score,
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic [DATA_W-1:0] new_score,
    input  logic [IDX_W-1:0]  new_idx,
    output logic [DATA_W-1:0] sel_score,
    output logic [IDX_W-1:0]  sel_idx
);

    always_comb begin
        sel_score = cur_score;
        sel_idx   = cur_idx;
        if (new_score > cur_score) begin
            sel_score = new_score;
            sel_idx   = new_idx;
        end
    end

endmodule

// File: rtl/class_select_ctrl.sv
// Streams NUM_CLASSES scores per frame and returns the index and value of the
// largest one, lowest index winning ties. One result per frame, abortable.
module class_select_ctrl
    import class_select_ctrl_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_score,
    output logic              busy
);

    // IDX_W must be wide enough to hold NUM_CLASSES-1.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   max_idx, max_idx_nxt;
    logic [DATA_W-1:0]  max_score, max_score_nxt;
    logic [DATA_W-1:0]  sel_score;
    logic [IDX_W-1:0]   sel_idx;

    class_max_update #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_max_update (
        .cur_score (max_score),
        .cur_idx   (max_idx),
        .new_score (in_data),
        .new_idx   (cnt),
        .sel_score (sel_score),
        .sel_idx   (sel_idx)
    );

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_index = max_idx;
    assign out_score = max_score;

    // Handshake: a beat moves on a rising edge with in_valid && in_ready, a
    // result on one with out_valid && out_ready; abort overrides both.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        max_idx_nxt   = max_idx;
        max_score_nxt = max_score;
        if (abort) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            max_idx_nxt   = '0;
            max_score_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        max_score_nxt = in_data;
                        max_idx_nxt   = '0;
                        cnt_nxt       = IDX_W'(1);
                        state_nxt     = ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        max_score_nxt = sel_score;
                        max_idx_nxt   = sel_idx;
                        if (cnt == LAST_IDX) begin
                            cnt_nxt   = '0;
                            state_nxt = DONE;
                        end else begin
                            cnt_nxt = cnt + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            max_idx   <= '0;
            max_score <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            max_idx   <= max_idx_nxt;
            max_score <= max_score_nxt;
        end
    end

endmodule
